// File: rtl/isqrt_arb_pkg.sv
// Shared widths and types for the isqrt arbiter slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package isqrt_arb_pkg;

  localparam int ISQRT_X_W = 32;
  localparam int ISQRT_Y_W = 16;

  typedef logic [ISQRT_X_W-1:0] isqrt_x_t;
  typedef logic [ISQRT_Y_W-1:0] isqrt_y_t;

endpackage

// File: rtl/isqrt_shared_arbiter_if.sv
// Requester, isqrt-issue and isqrt-return bundle for the shared isqrt arbiter.
// Latency: none (wires only).
// Backpressure: req_x_rdy is the only stall signal; the isqrt return path cannot stall.
interface isqrt_shared_arbiter_if
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic [N_REQ-1:0]           req_x_vld;
  logic [N_REQ*ISQRT_X_W-1:0] req_x;
  logic [N_REQ-1:0]           req_x_rdy;
  logic [N_REQ-1:0]           req_y_vld;
  isqrt_y_t                   req_y;
  logic                       isqrt_x_vld;
  isqrt_x_t                   isqrt_x;
  logic                       isqrt_y_vld;
  isqrt_y_t                   isqrt_y;
  logic [PTR_W:0]             tag_level;

  // Arbiter side
  modport slave (
    input  req_x_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_x_rdy, req_y_vld, req_y, isqrt_x_vld, isqrt_x, tag_level
  );

  // Requesters plus isqrt unit side
  modport master (
    output req_x_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_x_rdy, req_y_vld, req_y, isqrt_x_vld, isqrt_x, tag_level
  );

endinterface

// File: rtl/isqrt_arb_tag_fifo.sv
// Tag FIFO remembering the owner of every in-flight isqrt request.
// Latency: pop_dat shows the head combinationally; push visible at head next cycle.
// Backpressure: push ignored when full, pop ignored when empty; no full-bypass.
module isqrt_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage needs no reset: only entries below level are ever read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin share of one pipelined isqrt among N_REQ requesters; results routed back by tag.
// Latency: grant same cycle as request; result = isqrt latency + 1 registered cycle.
// Backpressure: all grants drop while the tag FIFO is full. ISQRT_SHARED_ARBITER_ERR_EN adds err.
module isqrt_shared_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef ISQRT_SHARED_ARBITER_ERR_EN
  output logic err,
`endif
  isqrt_shared_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] tag_head;
  logic             grant_vld;
  logic             issue;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   level;
  logic [N_REQ-1:0] rdy;
  logic [N_REQ-1:0] y_vld_q;
  isqrt_y_t         y_q;
  isqrt_x_t         x_sel;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_vld && bus.req_x_vld[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Outputs held at zero during reset; a full FIFO blocks issue even if a pop is under way
  assign issue = rst & grant_vld & ~fifo_full;
  assign pop   = bus.isqrt_y_vld & ~fifo_empty;

  // One-hot grant and radicand mux for the winner
  always_comb begin
    rdy   = '0;
    x_sel = '0;
    if (issue) begin
      rdy[grant_idx] = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_idx == IDX_W'(i)) x_sel = bus.req_x[ISQRT_X_W*i +: ISQRT_X_W];
      end
    end
  end

  assign bus.req_x_rdy   = rdy;
  assign bus.isqrt_x_vld = issue;
  assign bus.isqrt_x     = x_sel;
  assign bus.tag_level   = level;
  assign bus.req_y_vld   = y_vld_q;
  assign bus.req_y       = y_q;

  // Round-robin pointer moves just past the last winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  isqrt_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_dat (grant_idx),
    .pop      (pop),
    .pop_dat  (tag_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  // Route each in-order result to the owner of the head tag; untagged results are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_vld_q <= '0;
      y_q     <= '0;
    end else begin
      y_vld_q <= '0;
      if (pop) begin
        y_vld_q[tag_head] <= 1'b1;
        y_q               <= bus.isqrt_y;
      end
    end
  end

`ifdef ISQRT_SHARED_ARBITER_ERR_EN
  logic [N_REQ-1:0] pend_q;

  // Sticky protocol error: orphan result, or a request withdrawn before its grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      err    <= 1'b0;
    end else begin
      pend_q <= bus.req_x_vld & ~rdy;
      if ((bus.isqrt_y_vld && fifo_empty) || (|(pend_q & ~bus.req_x_vld))) err <= 1'b1;
    end
  end
`endif

endmodule
